// File: rtl/design_select_ctrl.sv
// Wishbone-controlled selector that enables one of several designs on a
// shared bus, always inserting an all-off dead time between activations.
module design_select_ctrl #(
    parameter int          NUM_DESIGNS = 4,
    parameter int          DEAD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [3:0]             wbs_sel_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NUM_DESIGNS-1:0] active_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_ON
    } state_t;

    localparam logic [8:0] LP_ND   = 9'(NUM_DESIGNS);
    localparam logic [7:0] LP_LAST = 8'(DEAD_CYCLES - 1);

    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic [8:0]             r_sel;
    logic [7:0]             r_cur;
    logic [NUM_DESIGNS-1:0] r_act;
    logic                   r_ack;
    logic [31:0]            r_dat;

    logic [31:0] w_off;
    logic        w_hit;
    logic        w_req;
    logic        w_wr_sel;
    logic        w_same;
    logic        w_eff;
    logic        w_tgt_ok;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_off    = wbs_adr_i - BASE_ADDR;
    assign w_hit    = (w_off[31:3] == 29'd0);
    assign w_req    = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
    assign w_wr_sel = w_req & wbs_we_i & ~w_off[2]
                    & (wbs_sel_i[1:0] == 2'b11);
    // Rewriting the live selection must not bounce the enable
    assign w_same   = (r_state == S_ON) & wbs_dat_i[8]
                    & (wbs_dat_i[7:0] == r_cur);
    assign w_eff    = w_wr_sel & ~w_same;
    assign w_tgt_ok = r_sel[8] & ({1'b0, r_sel[7:0]} < LP_ND);

    assign w_status = {22'd0, (r_state == S_BREAK), (|r_act), r_cur};
    assign w_rdata  = w_off[2] ? w_status : {23'd0, r_sel};

    function automatic logic [NUM_DESIGNS-1:0] onehot(input logic [7:0] idx);
        logic [NUM_DESIGNS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            v[i] = (idx == i[7:0]);
        end
        return v;
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_cur   <= '0;
            r_act   <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~wbs_we_i) ? w_rdata : 32'd0;
            if (w_eff) begin
                r_sel   <= wbs_dat_i[8:0];
                r_state <= S_BREAK;
                r_cnt   <= '0;
                r_act   <= '0;
                r_cur   <= '0;
            end else begin
                case (r_state)
                    S_BREAK: begin
                        if (r_cnt == LP_LAST) begin
                            r_cnt <= '0;
                            if (w_tgt_ok) begin
                                r_state <= S_ON;
                                r_act   <= onehot(r_sel[7:0]);
                                r_cur   <= r_sel[7:0];
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_IDLE, S_ON: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_act   <= '0;
                        r_cur   <= '0;
                    end
                endcase
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign active_o  = r_act;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Bench for design_select_ctrl: directed and random Wishbone traffic,
// scoreboarded against a cycle-level reference model.
module tb_design_select_ctrl;

    localparam int          ND   = 4;
    localparam int          DEAD = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [ND-1:0] active_o;

    design_select_ctrl #(
        .NUM_DESIGNS(ND),
        .DEAD_CYCLES(DEAD),
        .BASE_ADDR  (BASE)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_sel_i(sel),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .active_o (active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Reference model: countdown of remaining dead cycles, plain ints
    logic [31:0] exp_q[$];
    logic [8:0]  m_sel;
    logic [7:0]  m_idx;
    bit          m_on;
    int          m_left;
    bit          m_ack;
    logic [31:0] m_off;
    logic [31:0] m_stat;
    bit          m_req;
    bit          m_eff;

    function automatic logic [ND-1:0] exp_act();
        logic [ND-1:0] v;
        v = '0;
        if (m_on) v[m_idx[1:0]] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sel = '0; m_idx = '0; m_on = 0;
            m_left = 0; m_ack = 0;
            exp_q.delete();
        end else begin
            m_off  = adr - BASE;
            m_req  = stb && cyc && (m_off < 8) && !m_ack;
            m_stat = (m_on ? 32'(m_idx) : 32'd0)
                   | (m_on ? 32'h100 : 32'd0)
                   | (m_left > 0 ? 32'h200 : 32'd0);
            if (m_req)
                exp_q.push_back(we ? 32'd0 :
                                (m_off >= 4 ? m_stat : 32'(m_sel)));
            m_eff = m_req && we && (m_off < 4) && (sel[1:0] == 2'b11);
            if (m_eff && !(m_on && dat[8] && dat[7:0] == m_idx)) begin
                m_sel  = dat[8:0];
                m_on   = 0;
                m_left = DEAD;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && m_sel[8] && int'(m_sel[7:0]) < ND) begin
                    m_on  = 1;
                    m_idx = m_sel[7:0];
                end
            end
            m_ack = m_req;
        end
    end

    // Monitor
    int         zrun = 1000;
    logic [ND-1:0] prev_act = '0;
    logic [31:0] want;

    always @(negedge clk) begin
        if (rst) begin
            zrun = 1000;
            prev_act = '0;
        end else begin
            chk("ack", 32'(wbs_ack_o), 32'(m_ack));
            if (wbs_ack_o) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                chk("rdata", wbs_dat_o, want);
            end else begin
                chk("dat_idle", wbs_dat_o, 32'd0);
            end
            chk("active", 32'(active_o), 32'(exp_act()));
            chk("onehot0", 32'($onehot0(active_o)), 32'd1);
            if (active_o != 0 && prev_act == 0)
                chk("deadtime", 32'(zrun >= DEAD), 32'd1);
            zrun = (active_o == 0) ? zrun + 1 : 0;
            prev_act = active_o;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Classic cycle: strobe held through the ack cycle, then dropped
    task automatic wb(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
        stb = 1; cyc = 1; we = w; adr = a; dat = d; sel = s;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stb = 0; cyc = 0; we = 0; sel = 0;
    endtask

    task automatic async_rst();
        #3 rst = 1;
        #1;
        chk("rst_active", 32'(active_o), 32'd0);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        wb(0, BASE, 0, 4'hF);
        wb(0, BASE + 4, 0, 4'hF);
    endtask

    int op;
    logic [31:0] d;

    initial begin
        rst = 1; stb = 0; cyc = 0; we = 0;
        adr = 0; dat = 0; sel = 0;
        idle(3);
        rst = 0;

        wb(0, BASE + 4, 0, 4'hF);
        chk("reset_active", 32'(active_o), 32'd0);

        wb(1, BASE, 32'h102, 4'hF);
        chk("on2_break", 32'(active_o), 32'd0);
        idle(3);
        chk("on2_rise", 32'(active_o), 32'b0100);

        wb(1, BASE, 32'h101, 4'hF);
        chk("sw1_break", 32'(active_o), 32'd0);
        idle(2);
        chk("sw1_still_off", 32'(active_o), 32'd0);
        idle(1);
        chk("sw1_rise", 32'(active_o), 32'b0010);

        wb(1, BASE, 32'h101, 4'hF);
        chk("same_write", 32'(active_o), 32'b0010);
        wb(0, BASE + 4, 0, 4'hF);

        wb(1, BASE, 32'h109, 4'hF);
        idle(DEAD + 2);
        chk("oob_idle", 32'(active_o), 32'd0);
        wb(0, BASE, 0, 4'hF);
        wb(1, BASE, 32'h103, 4'b0001);
        wb(0, BASE, 0, 4'hF);
        wb(0, BASE + 4, 0, 4'hF);

        wb(1, BASE, 32'h102, 4'hF);
        idle(DEAD + 2);
        chk("pre_rst_on", 32'(active_o), 32'b0100);
        async_rst();

        wb(1, BASE, 32'h103, 4'hF);
        async_rst();

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                d = $urandom;
                d[8] = ($urandom_range(0, 5) != 0);
                d[7:0] = 8'($urandom_range(0, 5));
                wb(1, BASE + 32'($urandom_range(0, 3)), d,
                   ($urandom_range(0, 4) == 0) ? 4'b0001 : 4'b1111);
            end else if (op <= 7) begin
                wb(0, BASE + 32'($urandom_range(0, 7)), 0, 4'hF);
            end else if (op == 8) begin
                wb(1, BASE + 4, $urandom, 4'hF);
            end else begin
                wb(bit'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 0) ? BASE + 8 : BASE - 4,
                   $urandom, 4'hF);
            end
            idle(int'($urandom_range(0, 6)));
        end

        idle(DEAD + 4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
